uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of uart_rx; consumes its rx_out/rx_valid and presents bytes to the host with a valid/ready handshake.
- Decouples 9600-baud byte arrival from host service latency; flags lost bytes.
- Single clock domain (same clk as uart_rx), synchronous active-high reset.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- DATA_W, 8, byte width; matches the uart_rx output width.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  uart_rx rx_valid; pulse or level; a write occurs on its 0->1 transition only.
- in_data  input  DATA_W  uart_rx rx_out; sampled in the cycle the rising edge is detected.
- out_valid  output  1  head entry available (FIFO not empty).
- out_ready  input  1  host accepts the head entry.
- out_data  output  DATA_W  head entry; stable while out_valid=1 and no pop.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clr  input  1  one-cycle clear of overflow (and drop_cnt).
- drop_cnt  output  8  dropped-byte counter (see Optional Feature).

Behaviour:
- Reset:
  - count=0, empty=1, full=0, out_valid=0, overflow=0, drop_cnt=0.
  - Read and write pointers = 0. out_data is don't-care.
  - Edge-detect register in_valid_q resets to 1, so a level already high at reset release does not write.
- Edge detect:
  - in_valid_q <= in_valid every cycle.
  - wr_req = in_valid & ~in_valid_q.
  - A level held high for N cycles produces exactly one write.
- Pop: pop = out_valid & out_ready. out_data = mem[rd_ptr] (first-word-fall-through, combinational read of the head).
- Write: on wr_req, in_data is stored at wr_ptr in the same edge.
  - Data becomes visible on out_valid/out_data the next cycle. No same-cycle bypass.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0. Occupancy is tracked by the count register.
- Update rules per cycle:
  - wr_req only, not full: store, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - wr_req and pop, not full and not empty: store and advance both pointers; count unchanged.
  - wr_req and pop while full: pop frees the slot, the write is accepted, count stays DEPTH, no overflow.
  - wr_req while empty with out_ready=1: no pop (out_valid=0); the write is accepted.
  - wr_req while full without pop: byte dropped, pointers and count unchanged, overflow <= 1.
  - out_ready while empty: no effect.
- overflow:
  - Set by a drop; cleared by ovf_clr.
  - If a drop and ovf_clr occur in the same cycle, set wins (overflow=1).
- full, empty, out_valid are derived from the registered count. There are no combinational paths from in_valid or out_ready to them.
- Latency: in_valid rising edge at cycle N -> out_valid=1 at cycle N+1 (if previously empty).
- Reset asserted mid-operation empties the FIFO on the next edge; contents are discarded, with no partial state.

Optional Feature:
- Macro: UART_RXF_DROPCNT_EN.
- Defined:
  - drop_cnt increments by 1 per dropped byte and saturates at 255.
  - ovf_clr zeroes it.
  - Drop and ovf_clr in the same cycle -> drop_cnt=1.
- Undefined: drop_cnt is tied to 0 and no counter logic is present. overflow behaviour is unchanged.

Test Plan:
- Reset with in_valid held 1, release reset, hold in_valid 1 for 10 cycles -> count stays 0, out_valid=0.
- Single-byte path: pulse in_valid with in_data=8'hA5, out_ready=0 -> next cycle out_valid=1, out_data=A5, count=1. Then out_ready=1 for one cycle -> count=0, empty=1.
- Level input: in_valid held high 100 cycles with in_data=8'h3C -> exactly one entry (count=1).
- Fill and overflow, DEPTH=16:
  - Write 0x00..0x0F -> full=1, count=16.
  - Write 0x10 -> dropped, overflow=1, drop_cnt=1 (macro on) or 0 (macro off).
  - Drain 16 entries -> data 0x00..0x0F in order.
  - ovf_clr -> overflow=0.
- Simultaneous events:
  - While full, pop and write 0x55 in the same cycle -> count=16, overflow stays 0, 0x55 emerges last.
  - Drop and ovf_clr in the same cycle -> overflow=1.
- Wrap and reset:
  - Run 40 writes interleaved with pops (pointer wrap) -> output order matches input.
  - Assert reset with count=5 -> count=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_rx: edge-detected writes, first-word-fall-through reads, sticky overflow.
// Optional saturating dropped-byte counter enabled by defining UART_RXF_DROPCNT_EN.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              in_valid_q_reg;
    logic              overflow_reg;

    logic wr_req;
    logic pop;
    logic wr_accept;
    logic drop;

    // Status comes only from the registered count, keeping host-side inputs off these paths.
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign out_valid = ~empty;
    assign count     = count_reg;
    assign out_data  = mem[rd_ptr_reg];
    assign overflow  = overflow_reg;

    assign wr_req    = in_valid & ~in_valid_q_reg;
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign wr_accept = wr_req & (~full | pop);
    assign drop      = wr_req & full & ~pop;

    always_comb begin
        count_next = count_reg;
        if (wr_accept && !pop)
            count_next = count_reg + CW'(1);
        else if (!wr_accept && pop)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_q_reg <= 1'b1;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            in_valid_q_reg <= in_valid;
            count_reg      <= count_next;
            if (wr_accept)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (drop)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !reset)
            mem[wr_ptr_reg] <= in_data;
    end

`ifdef UART_RXF_DROPCNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt_reg <= '0;
        else if (ovf_clr)
            drop_cnt_reg <= drop ? 8'd1 : 8'd0;
        else if (drop && drop_cnt_reg != 8'hFF)
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for reset/edge-detect/single byte, then hand sequences.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b1;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       full, empty, overflow;
    logic       ovf_clr = 1'b0;
    logic [7:0] drop_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty), .overflow(overflow),
        .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       clr;
        int         cnt;
        logic       chk_d;
        logic [7:0] exp_d;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic iv, logic [7:0] d, logic ordy, logic clr,
                                int cnt, logic chk_d, logic [7:0] exp_d, logic ovf);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
        v.cnt = cnt; v.chk_d = chk_d; v.exp_d = exp_d; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic iv, input logic [7:0] d,
                       input logic ordy, input logic clr);
        reset = rst; in_valid = iv; in_data = d; out_ready = ordy; ovf_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input int cnt, input logic ovf);
        chk({tag, ".count"}, int'(count), cnt);
        chk({tag, ".out_valid"}, int'(out_valid), int'(cnt != 0));
        chk({tag, ".empty"}, int'(empty), int'(cnt == 0));
        chk({tag, ".full"}, int'(full), int'(cnt == DEPTH));
        chk({tag, ".overflow"}, int'(overflow), int'(ovf));
    endtask

    task automatic wr(input logic [7:0] d);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, d, 1'b0, 1'b0);
    endtask

    int exp_drops;
    logic [7:0] q[$];
    logic [7:0] v8;

    initial begin
        // Reset with in_valid held high, release with the level still high: no write.
        tbl.push_back(mk(1, 1, 8'h11, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 8'h11, 0, 0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
        // Single byte: write visible next cycle, pop empties.
        tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 8'hA5, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
        // Write while empty with out_ready high is accepted.
        tbl.push_back(mk(0, 1, 8'h7E, 1, 0, 1, 1, 8'h7E, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr);
            chk_status($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ovf);
            if (tbl[i].chk_d)
                chk($sformatf("vec%0d.out_data", i), int'(out_data), int'(tbl[i].exp_d));
            chk($sformatf("vec%0d.drop_cnt", i), int'(drop_cnt), 0);
        end

        // Level held 100 cycles -> one entry.
        for (int i = 0; i < 100; i++)
            cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk_status("level", 1, 1'b0);
        chk("level.out_data", int'(out_data), 8'h3C);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk_status("level_pop", 0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill, overflow, drain in order, clear.
        for (int i = 0; i < DEPTH; i++)
            wr(8'(i));
        chk_status("fill", DEPTH, 1'b0);
        wr(8'h10);
`ifdef UART_RXF_DROPCNT_EN
        exp_drops = 1;
`else
        exp_drops = 0;
`endif
        chk_status("drop", DEPTH, 1'b1);
        chk("drop.drop_cnt", int'(drop_cnt), exp_drops);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d.out_data", i), int'(out_data), i);
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_status("drained", 0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_status("ovf_clr", 0, 1'b0);
        chk("ovf_clr.drop_cnt", int'(drop_cnt), 0);

        // Full: pop and write in the same cycle, then drop with ovf_clr together.
        for (int i = 0; i < DEPTH; i++)
            wr(8'h20 + 8'(i));
        cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        chk_status("simul", DEPTH, 1'b0);
        chk("simul.out_data", int'(out_data), 8'h21);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
        chk_status("drop_clr", DEPTH, 1'b1);
        chk("drop_clr.drop_cnt", int'(drop_cnt), exp_drops);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            v8 = (i == DEPTH - 1) ? 8'h55 : 8'h21 + 8'(i);
            chk($sformatf("drain2_%0d.out_data", i), int'(out_data), int'(v8));
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_status("drain2", 0, 1'b0);

        // 40 writes interleaved with pops, three entries kept in flight to wrap pointers.
        for (int i = 0; i < 3; i++) begin
            v8 = 8'h90 + 8'(i);
            wr(v8);
            q.push_back(v8);
        end
        for (int i = 0; i < 40; i++) begin
            v8 = 8'(i * 7 + 3);
            cyc(1'b0, 1'b1, v8, 1'b0, 1'b0);
            q.push_back(v8);
            chk($sformatf("wrap%0d.count", i), int'(count), 4);
            chk($sformatf("wrap%0d.out_data", i), int'(out_data), int'(q[0]));
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            void'(q.pop_front());
        end
        chk_status("wrap_end", 3, 1'b0);
        chk("wrap_end.out_data", int'(out_data), int'(q[0]));

        // Reset with five entries held.
        wr(8'hC1);
        wr(8'hC2);
        chk_status("pre_rst", 5, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_status("mid_rst", 0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_status("post_rst", 0, 1'b0);
        wr(8'hE7);
        chk_status("post_rst_wr", 1, 1'b0);
        chk("post_rst_wr.out_data", int'(out_data), 8'hE7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
